// File: rtl/driver_bus_monitor.sv
// driver_bus_monitor: receive-side decoder for the LED driver serial bus.
// Oversamples SCLK/GCLK/LAT/SIN on clk_hse, rebuilds the driver shift
// register, decodes LAT commands by SCLK edge count while LAT is high,
// follows the FC write-enable sequence and measures GCLK edges per segment.
//
// Ports:
//   clk_hse           sampling clock (>= 2x SCLK rate)
//   nrst              asynchronous active-low reset
//   drv_sclk/gclk/lat/sin   monitored bus lines (raw, asynchronous)
//   cmd_valid         one-cycle pulse per decoded command
//   cmd_code          1 WRTGS, 2 LATGS, 3 WRTFC, 4 FCWRTEN, 5 LINERESET, 7 UNKNOWN
//   cmd_data          shift register contents at LAT fall
//   conf_reg          last accepted FC data; conf_valid pulses on update
//   fc_write_en       FC write armed
//   gs_wrt_count      WRTGS commands since last LATGS/LINERESET (sat 15)
//   gclk_count        GCLK rising edges in previous segment; gclk_count_valid pulses
//   err_count         UNKNOWN + WRTFC-without-enable events (sat 255)
module driver_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SR_WIDTH    = 48,
  parameter int unsigned GCLK_CNT_W  = 11
) (
  input  logic                  clk_hse,
  input  logic                  nrst,
  input  logic                  drv_sclk,
  input  logic                  drv_gclk,
  input  logic                  drv_lat,
  input  logic                  drv_sin,
  output logic                  cmd_valid,
  output logic [2:0]            cmd_code,
  output logic [SR_WIDTH-1:0]   cmd_data,
  output logic [SR_WIDTH-1:0]   conf_reg,
  output logic                  conf_valid,
  output logic                  fc_write_en,
  output logic [3:0]            gs_wrt_count,
  output logic [GCLK_CNT_W-1:0] gclk_count,
  output logic                  gclk_count_valid,
  output logic [7:0]            err_count
);

  localparam int unsigned LAT_CNT_W = 5;
  localparam int unsigned GS_W      = 4;
  localparam int unsigned ERR_W     = 8;

  localparam logic [2:0] CMD_WRTGS     = 3'd1;
  localparam logic [2:0] CMD_LATGS     = 3'd2;
  localparam logic [2:0] CMD_WRTFC     = 3'd3;
  localparam logic [2:0] CMD_FCWRTEN   = 3'd4;
  localparam logic [2:0] CMD_LINERESET = 3'd5;
  localparam logic [2:0] CMD_UNKNOWN   = 3'd7;

  typedef enum logic [0:0] {
    FC_IDLE  = 1'b0,
    FC_ARMED = 1'b1
  } fc_state_t;

  // Synchronisers, identical depth for all four lines
  logic [SYNC_STAGES-1:0] r_sync_sclk;
  logic [SYNC_STAGES-1:0] r_sync_gclk;
  logic [SYNC_STAGES-1:0] r_sync_lat;
  logic [SYNC_STAGES-1:0] r_sync_sin;

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      r_sync_sclk <= '0;
      r_sync_gclk <= '0;
      r_sync_lat  <= '0;
      r_sync_sin  <= '0;
    end else begin
      r_sync_sclk <= {r_sync_sclk[SYNC_STAGES-2:0], drv_sclk};
      r_sync_gclk <= {r_sync_gclk[SYNC_STAGES-2:0], drv_gclk};
      r_sync_lat  <= {r_sync_lat[SYNC_STAGES-2:0], drv_lat};
      r_sync_sin  <= {r_sync_sin[SYNC_STAGES-2:0], drv_sin};
    end
  end

  logic w_s_sclk, w_s_gclk, w_s_lat, w_s_sin;
  assign w_s_sclk = r_sync_sclk[SYNC_STAGES-1];
  assign w_s_gclk = r_sync_gclk[SYNC_STAGES-1];
  assign w_s_lat  = r_sync_lat[SYNC_STAGES-1];
  assign w_s_sin  = r_sync_sin[SYNC_STAGES-1];

  // Delayed copies for edge detection
  logic r_sclk_d, r_gclk_d, r_lat_d;

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      r_sclk_d <= 1'b0;
      r_gclk_d <= 1'b0;
      r_lat_d  <= 1'b0;
    end else begin
      r_sclk_d <= w_s_sclk;
      r_gclk_d <= w_s_gclk;
      r_lat_d  <= w_s_lat;
    end
  end

  logic w_sclk_rise, w_gclk_rise, w_lat_rise, w_lat_fall;
  assign w_sclk_rise = w_s_sclk & ~r_sclk_d;
  assign w_gclk_rise = w_s_gclk & ~r_gclk_d;
  assign w_lat_rise  = w_s_lat  & ~r_lat_d;
  assign w_lat_fall  = ~w_s_lat & r_lat_d;

  // Event stage: edges and levels registered together so every decode
  // decision sees one coherent bus snapshot
  logic r_ev_sclk_rise, r_ev_gclk_rise, r_ev_lat_rise, r_ev_lat_fall;
  logic r_ev_lat, r_ev_sin;

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      r_ev_sclk_rise <= 1'b0;
      r_ev_gclk_rise <= 1'b0;
      r_ev_lat_rise  <= 1'b0;
      r_ev_lat_fall  <= 1'b0;
      r_ev_lat       <= 1'b0;
      r_ev_sin       <= 1'b0;
    end else begin
      r_ev_sclk_rise <= w_sclk_rise;
      r_ev_gclk_rise <= w_gclk_rise;
      r_ev_lat_rise  <= w_lat_rise;
      r_ev_lat_fall  <= w_lat_fall;
      r_ev_lat       <= w_s_lat;
      r_ev_sin       <= w_s_sin;
    end
  end

  // Driver shift register: first bit in ends up as MSB
  logic [SR_WIDTH-1:0] r_sr;

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      r_sr <= '0;
    end else if (r_ev_sclk_rise) begin
      r_sr <= {r_sr[SR_WIDTH-2:0], r_ev_sin};
    end
  end

  // SCLK edges while LAT high; an edge coincident with the LAT rise counts
  logic [LAT_CNT_W-1:0] r_lat_cnt;

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      r_lat_cnt <= '0;
    end else if (r_ev_lat_rise) begin
      r_lat_cnt <= LAT_CNT_W'(r_ev_sclk_rise);
    end else if (r_ev_sclk_rise && r_ev_lat && (r_lat_cnt != '1)) begin
      r_lat_cnt <= r_lat_cnt + LAT_CNT_W'(1);
    end
  end

  // Command decode from edge count
  logic       w_dec;
  logic [2:0] w_dec_code;

  assign w_dec = r_ev_lat_fall;

  always_comb begin
    w_dec_code = CMD_UNKNOWN;
    case (r_lat_cnt)
      LAT_CNT_W'(1):  w_dec_code = CMD_WRTGS;
      LAT_CNT_W'(3):  w_dec_code = CMD_LATGS;
      LAT_CNT_W'(5):  w_dec_code = CMD_WRTFC;
      LAT_CNT_W'(7):  w_dec_code = CMD_LINERESET;
      LAT_CNT_W'(15): w_dec_code = CMD_FCWRTEN;
      default:        w_dec_code = CMD_UNKNOWN;
    endcase
  end

  // FC write-enable state machine
  fc_state_t r_fc_state;
  fc_state_t w_fc_next;
  logic      w_conf_load;
  logic      w_fc_err;

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      r_fc_state <= FC_IDLE;
    end else begin
      r_fc_state <= w_fc_next;
    end
  end

  always_comb begin
    w_fc_next   = r_fc_state;
    w_conf_load = 1'b0;
    w_fc_err    = 1'b0;
    if (w_dec) begin
      case (r_fc_state)
        FC_IDLE: begin
          if (w_dec_code == CMD_FCWRTEN) begin
            w_fc_next = FC_ARMED;
          end else if (w_dec_code == CMD_WRTFC) begin
            w_fc_err = 1'b1;
          end
        end
        FC_ARMED: begin
          if (w_dec_code == CMD_WRTFC) begin
            w_fc_next   = FC_IDLE;
            w_conf_load = 1'b1;
          end else if (w_dec_code != CMD_FCWRTEN) begin
            w_fc_next = FC_IDLE;
          end
        end
        default: w_fc_next = FC_IDLE;
      endcase
    end
  end

  logic w_seg_end;
  logic w_err_inc;
  assign w_seg_end = w_dec && ((w_dec_code == CMD_LATGS) || (w_dec_code == CMD_LINERESET));
  assign w_err_inc = w_dec && ((w_dec_code == CMD_UNKNOWN) || w_fc_err);

  // Command, configuration and error outputs
  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_data    <= '0;
      conf_reg    <= '0;
      conf_valid  <= 1'b0;
      fc_write_en <= 1'b0;
      err_count   <= '0;
    end else begin
      cmd_valid   <= w_dec;
      conf_valid  <= w_conf_load;
      fc_write_en <= (w_fc_next == FC_ARMED);
      if (w_dec) begin
        cmd_code <= w_dec_code;
        cmd_data <= r_sr;
      end
      if (w_conf_load) begin
        conf_reg <= r_sr;
      end
      if (w_err_inc && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  // Grayscale write tracking
  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      gs_wrt_count <= '0;
    end else if (w_seg_end) begin
      gs_wrt_count <= '0;
    end else if (w_dec && (w_dec_code == CMD_WRTGS) && (gs_wrt_count != '1)) begin
      gs_wrt_count <= gs_wrt_count + GS_W'(1);
    end
  end

  // GCLK edges per segment; an edge in the closing cycle opens the next segment
  logic [GCLK_CNT_W-1:0] r_gclk_cnt;

  always_ff @(posedge clk_hse or negedge nrst) begin
    if (!nrst) begin
      r_gclk_cnt       <= '0;
      gclk_count       <= '0;
      gclk_count_valid <= 1'b0;
    end else begin
      gclk_count_valid <= w_seg_end;
      if (w_seg_end) begin
        gclk_count <= r_gclk_cnt;
        r_gclk_cnt <= GCLK_CNT_W'(r_ev_gclk_rise);
      end else if (r_ev_gclk_rise && (r_gclk_cnt != '1)) begin
        r_gclk_cnt <= r_gclk_cnt + GCLK_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_driver_bus_monitor.sv
module tb_driver_bus_monitor;

  localparam int unsigned SYNC = 2;
  localparam int unsigned SW   = 48;
  localparam int unsigned GW   = 11;

  logic          clk_hse = 1'b0;
  logic          nrst;
  logic          drv_sclk, drv_gclk, drv_lat, drv_sin;
  logic          cmd_valid;
  logic [2:0]    cmd_code;
  logic [SW-1:0] cmd_data;
  logic [SW-1:0] conf_reg;
  logic          conf_valid;
  logic          fc_write_en;
  logic [3:0]    gs_wrt_count;
  logic [GW-1:0] gclk_count;
  logic          gclk_count_valid;
  logic [7:0]    err_count;

  driver_bus_monitor #(.SYNC_STAGES(SYNC), .SR_WIDTH(SW), .GCLK_CNT_W(GW)) dut (
    .clk_hse(clk_hse), .nrst(nrst),
    .drv_sclk(drv_sclk), .drv_gclk(drv_gclk), .drv_lat(drv_lat), .drv_sin(drv_sin),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_data(cmd_data),
    .conf_reg(conf_reg), .conf_valid(conf_valid), .fc_write_en(fc_write_en),
    .gs_wrt_count(gs_wrt_count), .gclk_count(gclk_count),
    .gclk_count_valid(gclk_count_valid), .err_count(err_count)
  );

  always #5 clk_hse = ~clk_hse;

  int cyc = 0;
  always @(posedge clk_hse) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Protocol-level model: bit history, LAT edge count, FC/GS/GCLK/error bookkeeping
  typedef struct {
    logic [2:0]  code;
    logic [47:0] data;
    bit          conf_v;
    logic [47:0] conf;
    int          gs;
    int          err;
    bit          fcen;
    bit          gcv;
    int          gcount;
    int          fall_cyc;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_bits[$];
  int          m_cnt   = 0;
  bit          m_lat   = 0;
  bit          m_armed = 0;
  logic [47:0] m_conf  = '0;
  int          m_gs    = 0;
  int          m_err   = 0;
  int          m_gclk  = 0;

  int          seen_code[8];
  logic [2:0]  last_code = '0;
  int          n_conf_pulse = 0;
  int          n_gcv_pulse  = 0;

  function automatic logic [47:0] m_window();
    logic [47:0] w;
    int idx;
    for (int i = 0; i < 48; i++) begin
      idx = m_bits.size() - 48 + i;
      w[47-i] = (idx >= 0) ? m_bits[idx] : 1'b0;
    end
    return w;
  endfunction

  function automatic logic [2:0] code_of(input int n);
    case (n)
      1:       return 3'd1;
      3:       return 3'd2;
      5:       return 3'd3;
      7:       return 3'd5;
      15:      return 3'd4;
      default: return 3'd7;
    endcase
  endfunction

  task automatic m_decode();
    exp_t e;
    e.code   = code_of(m_cnt);
    e.data   = m_window();
    e.conf_v = 1'b0;
    e.gcv    = 1'b0;
    e.gcount = 0;
    if (e.code == 3'd4) begin
      m_armed = 1'b1;
    end else if (e.code == 3'd3) begin
      if (m_armed) begin
        m_conf   = e.data;
        e.conf_v = 1'b1;
      end else if (m_err < 255) begin
        m_err++;
      end
      m_armed = 1'b0;
    end else begin
      m_armed = 1'b0;
      if (e.code == 3'd7 && m_err < 255) m_err++;
    end
    if (e.code == 3'd1 && m_gs < 15) m_gs++;
    if (e.code == 3'd2 || e.code == 3'd5) begin
      m_gs     = 0;
      e.gcv    = 1'b1;
      e.gcount = (m_gclk > 2047) ? 2047 : m_gclk;
      m_gclk   = 0;
    end
    e.conf     = m_conf;
    e.gs       = m_gs;
    e.err      = m_err;
    e.fcen     = m_armed;
    e.fall_cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_hse);
  endtask

  task automatic set_lat(input bit v);
    if (v && !m_lat) m_cnt = 0;
    if (!v && m_lat) m_decode();
    m_lat   = v;
    drv_lat = v;
  endtask

  task automatic send_bit(input bit b, input bit l);
    set_lat(l);
    drv_sin = b;
    tick(2);
    drv_sclk = 1'b1;
    m_bits.push_back(b);
    if (m_lat && m_cnt < 31) m_cnt++;
    tick(2);
    drv_sclk = 1'b0;
  endtask

  task automatic lat_low();
    set_lat(1'b0);
    tick(2);
  endtask

  task automatic send_word(input logic [47:0] w, input int lat_edges);
    for (int i = 0; i < 48; i++) send_bit(w[47-i], i >= 48 - lat_edges);
    lat_low();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b1);
    lat_low();
  endtask

  task automatic gclk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      drv_gclk = 1'b1;
      m_gclk++;
      tick(2);
      drv_gclk = 1'b0;
      tick(2);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick(1);
      t++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    tick(2);
  endtask

  // Compare process
  always @(negedge clk_hse) begin
    exp_t e;
    if (nrst === 1'b1) begin
      if (conf_valid === 1'b1) n_conf_pulse++;
      if (gclk_count_valid === 1'b1) n_gcv_pulse++;
      if (cmd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 64'(cmd_code), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_code", 64'(cmd_code), 64'(e.code));
          check("cmd_data", 64'(cmd_data), 64'(e.data));
          check("conf_valid", 64'(conf_valid), 64'(e.conf_v));
          check("conf_reg", 64'(conf_reg), 64'(e.conf));
          check("gs_wrt_count", 64'(gs_wrt_count), 64'(e.gs));
          check("err_count", 64'(err_count), 64'(e.err));
          check("fc_write_en", 64'(fc_write_en), 64'(e.fcen));
          check("gclk_count_valid", 64'(gclk_count_valid), 64'(e.gcv));
          if (e.gcv) check("gclk_count", 64'(gclk_count), 64'(e.gcount));
          check("latency", 64'(cyc - e.fall_cyc), 64'(SYNC + 2));
          seen_code[int'(cmd_code)]++;
          last_code = cmd_code;
        end
      end else begin
        check("conf_valid_idle", 64'(conf_valid), 64'd0);
        check("gclk_valid_idle", 64'(gclk_count_valid), 64'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    check({tag, "_cmd_code"}, 64'(cmd_code), 64'd0);
    check({tag, "_cmd_data"}, 64'(cmd_data), 64'd0);
    check({tag, "_conf_reg"}, 64'(conf_reg), 64'd0);
    check({tag, "_conf_valid"}, 64'(conf_valid), 64'd0);
    check({tag, "_fc_write_en"}, 64'(fc_write_en), 64'd0);
    check({tag, "_gs"}, 64'(gs_wrt_count), 64'd0);
    check({tag, "_gclk_count"}, 64'(gclk_count), 64'd0);
    check({tag, "_gclk_valid"}, 64'(gclk_count_valid), 64'd0);
    check({tag, "_err"}, 64'(err_count), 64'd0);
  endtask

  initial begin
    int gcv_before;
    logic [47:0] w;
    nrst = 1'b0;
    drv_sclk = 1'b0; drv_gclk = 1'b0; drv_lat = 1'b0; drv_sin = 1'b0;
    for (int i = 0; i < 8; i++) seen_code[i] = 0;
    tick(3);
    check_all_zero("reset");
    nrst = 1'b1;
    tick(3);

    // FC write sequence
    pulses(15);
    drain();
    check("fcwrten_armed", 64'(fc_write_en), 64'd1);
    check("fcwrten_code", 64'(last_code), 64'd4);
    send_word(48'hA5A5_0F0F_1234, 5);
    drain();
    check("fc_conf_lit", 64'(conf_reg), 64'hA5A5_0F0F_1234);
    check("fc_code_lit", 64'(last_code), 64'd3);
    check("fc_en_lit", 64'(fc_write_en), 64'd0);
    check("fc_err_lit", 64'(err_count), 64'd0);
    check("fc_conf_pulses", 64'(n_conf_pulse), 64'd1);

    // Grayscale stream: 7 WRTGS then LATGS
    for (int k = 0; k < 7; k++) begin
      w = 48'h1111_0000_0000 * 48'(k + 1) + 48'(k);
      send_word(w, 1);
    end
    drain();
    check("stream_gs7_lit", 64'(gs_wrt_count), 64'd7);
    check("stream_wrtgs_lit", 64'(seen_code[1]), 64'd7);
    send_word(48'hFEDC_BA98_7654, 3);
    drain();
    check("stream_latgs_lit", 64'(last_code), 64'd2);
    check("stream_gs0_lit", 64'(gs_wrt_count), 64'd0);
    check("stream_data_lit", 64'(cmd_data), 64'hFEDC_BA98_7654);

    // GCLK segment
    pulses(3);
    drain();
    gcv_before = n_gcv_pulse;
    gclk_pulses(512);
    pulses(3);
    drain();
    check("gclk_512_lit", 64'(gclk_count), 64'd512);
    check("gclk_pulse_lit", 64'(n_gcv_pulse - gcv_before), 64'd1);

    // Bad commands
    pulses(4);
    drain();
    check("bad_code_lit", 64'(last_code), 64'd7);
    check("bad_err1_lit", 64'(err_count), 64'd1);
    pulses(5);
    drain();
    check("wrtfc_noen_err_lit", 64'(err_count), 64'd2);
    check("wrtfc_noen_conf_lit", 64'(conf_reg), 64'hA5A5_0F0F_1234);

    // SCLK rise coincident with LAT fall: one counted edge only
    send_bit(1'b1, 1'b1);
    drv_sin = 1'b0;
    tick(2);
    drv_sclk = 1'b1;
    set_lat(1'b0);
    m_bits.push_back(1'b0);
    tick(2);
    drv_sclk = 1'b0;
    tick(2);
    drain();
    check("boundary_wrtgs_lit", 64'(last_code), 64'd1);

    // Saturating LAT count
    pulses(40);
    drain();
    check("sat_code_lit", 64'(last_code), 64'd7);
    check("sat_err_lit", 64'(err_count), 64'd3);

    // Reset mid-command
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    nrst = 1'b0;
    drv_lat = 1'b0; drv_sclk = 1'b0; drv_sin = 1'b0; drv_gclk = 1'b0;
    m_lat = 0; m_cnt = 0; m_armed = 0; m_conf = '0;
    m_gs = 0; m_err = 0; m_gclk = 0;
    m_bits.delete();
    exp_q.delete();
    tick(1);
    check_all_zero("midrst");
    tick(3);
    nrst = 1'b1;
    tick(6);
    check("post_rst_no_cmd", 64'(exp_q.size()), 64'd0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    lat_low();
    drain();
    check("post_rst_code_lit", 64'(last_code), 64'd1);
    check("post_rst_data_lit", 64'(cmd_data), 64'h5);
    check("post_rst_gs_lit", 64'(gs_wrt_count), 64'd1);

    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/driver_bus_monitor.md
Name: driver_bus_monitor

Overview:
- Receive-side decoder for the LED driver serial bus (SCLK/GCLK/LAT/SIN): the driver end of the protocol the driver controller emits.
- Oversamples the bus on clk_hse, rebuilds the 48-bit driver shift register and decodes LAT commands by counting SCLK rising edges while LAT is high.
- Tracks the function-control (FC) register write sequence and GCLK cycles per segment.
- Used as an in-FPGA bus checker and simulation scoreboard front-end.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each bus input; minimum 2.
- SR_WIDTH, 48, driver shift register width in bits.
- GCLK_CNT_W, 11, width of the GCLK-per-segment counter.

Ports:
- clk_hse  in  1  sampling clock, at least 2x the SCLK rate.
- nrst  in  1  reset, asynchronous, active-low.
- drv_sclk  in  1  monitored SCLK.
- drv_gclk  in  1  monitored GCLK.
- drv_lat  in  1  monitored LAT.
- drv_sin  in  1  monitored SIN lane, one of the 30.
- cmd_valid  out  1  one-cycle pulse when a command has been decoded.
- cmd_code  out  3  0 none, 1 WRTGS, 2 LATGS, 3 WRTFC, 4 FCWRTEN, 5 LINERESET, 7 UNKNOWN.
- cmd_data  out  SR_WIDTH  shift register contents at LAT fall.
- conf_reg  out  SR_WIDTH  last accepted FC data.
- conf_valid  out  1  one-cycle pulse when conf_reg updates.
- fc_write_en  out  1  FC write enabled (FCWRTEN seen, WRTFC not yet seen).
- gs_wrt_count  out  4  WRTGS commands since the last LATGS; saturates at 15.
- gclk_count  out  GCLK_CNT_W  GCLK rising edges in the previous segment.
- gclk_count_valid  out  1  one-cycle pulse when gclk_count updates.
- err_count  out  8  UNKNOWN commands plus WRTFC-without-enable events; saturates at 255.

Behaviour:
- Reset: every output and internal register clears to 0, including all sync stages. Reset asserted mid-command discards any partial command; no cmd_valid is issued for it.
- Input sampling
  - All four inputs pass through SYNC_STAGES flip-flops, identical depth for each.
  - Edges are detected by comparing the last sync stage with one extra delayed copy.
  - All decode logic uses only the synced signals, called s_sclk, s_lat, s_sin, s_gclk below.
- Shift register: on an s_sclk rising edge, sr <= {sr[SR_WIDTH-2:0], s_sin}, so the first bit shifted in ends up as the MSB. Shifting happens whether LAT is high or low.
- LAT edge counter (5-bit, saturating at 31)
  - Cleared on an s_lat rising edge.
  - Incremented on an s_sclk rising edge in a cycle where s_lat = 1.
  - Same-cycle events: if s_sclk rises in the same cycle s_lat rises, the edge counts. If s_sclk rises in the same cycle s_lat falls (s_lat = 0), the edge does not count.
- Decode on s_lat falling edge
  - Count mapping: 1 -> WRTGS, 3 -> LATGS, 5 -> WRTFC, 7 -> LINERESET, 15 -> FCWRTEN, anything else (including 0 and 31) -> UNKNOWN.
  - Registered outputs: cmd_valid = 1 for one cycle with cmd_code, and cmd_data = sr including bits shifted during LAT high.
  - Latency from the raw drv_lat fall to cmd_valid is SYNC_STAGES + 2 clk_hse cycles.
- FC state machine, states FC_IDLE and FC_ARMED:
  - FC_IDLE --FCWRTEN--> FC_ARMED. fc_write_en = 1 while in FC_ARMED.
  - FC_ARMED --WRTFC--> FC_IDLE, with conf_reg <= sr and conf_valid pulsed in the same cycle as cmd_valid.
  - FC_ARMED --any other decoded command--> FC_IDLE, no conf update.
  - WRTFC in FC_IDLE: conf_reg is unchanged and err_count increments.
  - FCWRTEN in FC_ARMED stays in FC_ARMED.
- GS tracking
  - WRTGS increments gs_wrt_count.
  - LATGS and LINERESET clear gs_wrt_count in the same cycle as cmd_valid.
  - A LATGS itself is not counted as a WRTGS.
- GCLK segment counter
  - Counts s_gclk rising edges and saturates at all-ones.
  - On LATGS or LINERESET decode: gclk_count <= counter, gclk_count_valid pulses, and the counter restarts at 0.
  - A GCLK rising edge in that same cycle counts toward the new segment.
- err_count increments on each UNKNOWN command and each WRTFC without enable, at most +1 per decode.

Test Plan:
- FC write: 15 SCLK edges with LAT high, then 48 bits 0xA5A5_0F0F_1234 with LAT high on the last 5 edges -> cmd_code 4 then cmd_code 3, conf_reg = 0xA5A50F0F1234, conf_valid one pulse, fc_write_en back to 0, err_count = 0.
- Stream: 8 x 48-bit words with LAT high on the final edge of the first 7, then a LATGS (3 edges) on the 8th -> seven cmd_code 1 pulses, gs_wrt_count reaching 7, then cmd_code 2 with gs_wrt_count = 0.
- GCLK: 512 GCLK rising edges between two LATGS commands -> gclk_count = 512 with one gclk_count_valid pulse on the second LATGS.
- Bad command: LAT high over 4 SCLK edges -> cmd_code 7, err_count = 1. WRTFC with no prior FCWRTEN -> err_count = 2, conf_reg unchanged.
- Boundary: SCLK rise in the same sampled cycle as the LAT fall, after 1 counted edge -> WRTGS (count 1, not 2). LAT high for 40 edges -> count saturates at 31, UNKNOWN.
- Reset: assert nrst after 2 of 3 LATGS edges -> all outputs 0, no cmd_valid. After release, a clean WRTGS decodes normally.
